alu_cmd_issue: RTL and testbench
================================

# alu_cmd_issue

Command issue and result capture stage for the 16-bit combinational ALU (add/sub/and/or/xor). Buffers operand/opcode commands arriving on a valid/ready interface in a small FIFO, and drives the ALU operand and select inputs from the FIFO head. Captures the ALU result into a registered response slot with its own valid/ready handshake, an illegal-opcode flag and a wrapping sequence number. It is the stage directly in front of, and directly behind, the ALU.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥ 2
- WIDTH, 16, operand/result width; fixed to match the ALU
- SEQW, 8, response sequence-number width
---
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept a command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_sel  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor; 101–111 illegal
- alu_a  out  WIDTH  to ALU operand a
- alu_b  out  WIDTH  to ALU operand b
- alu_sel  out  3  to ALU sel
- alu_out  in  WIDTH  from ALU out (combinational)
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_data  out  WIDTH  captured ALU result
- rsp_sel  out  3  opcode that produced rsp_data
- rsp_illegal  out  1  rsp_sel was 101–111
- rsp_seq  out  SEQW  issue order number, wraps
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: `cmd_valid && cmd_ready` on a rising edge writes {cmd_a, cmd_b, cmd_sel} at the write pointer.
- `cmd_ready = !full && !rst`. It does not look ahead to a same-cycle pop, so a full FIFO never accepts, even while popping.
- Head drive: when the FIFO is non-empty, alu_a/alu_b/alu_sel equal the head entry combinationally. When empty they are all zero.
- Pop/issue condition: `!empty && (!rsp_valid || rsp_ready)`. On that edge:
  - rsp_data ← alu_out
  - rsp_sel ← head sel
  - rsp_illegal ← (head sel ≥ 3'b101)
  - rsp_seq ← issue counter; the issue counter then increments
  - rsp_valid ← 1
  - read pointer advances
- Response drain: `rsp_valid && rsp_ready` with no pop clears rsp_valid. A drain and pop on the same edge reloads the slot back-to-back, so rsp_valid stays 1.
- Illegal opcodes are issued normally. The ALU returns 0, so rsp_data = 0 and rsp_illegal = 1. There is no stall and no drop.
- Pointers are log2(DEPTH) bits and wrap naturally. count = pushes − pops and is updated on every edge.
  - Simultaneous push and pop: count unchanged.
  - Push into empty: the entry becomes head and is visible on alu_* in the next cycle.
- Issue counter wraps from 2^SEQW−1 to 0 with no flag.
- Total capacity with no draining is DEPTH + 1 commands: DEPTH in the FIFO plus 1 in the response slot.

## Timing
- Reset, sampled at an edge with rst = 1:
  - pointers, count and issue counter reset to 0
  - rsp_valid, rsp_data, rsp_sel, rsp_illegal, rsp_seq reset to 0
  - alu_a/alu_b/alu_sel = 0 because the FIFO is empty
  - cmd_ready = 0 while rst is high and 1 in the first cycle after
- Reset mid-operation discards all buffered commands and any held response. No partial response is emitted.
- Latency: command accepted at edge k into an empty FIFO with a free slot → rsp_valid = 1 after edge k+1. Minimum is 2 cycles from cmd_valid to rsp_valid.
- Throughput: 1 command per cycle when rsp_ready is held high.
- rsp_* is stable while `rsp_valid && !rsp_ready`.
- ALU path: head register → alu_* → ALU → alu_out → rsp_data, within one cycle. No combinational path from cmd_* to alu_* or from rsp_ready to cmd_ready.

## Test plan
- Single add: cmd {0x1234, 0x0001, 000}, rsp_ready = 1 → rsp_data = 0x1235, rsp_sel = 000, rsp_illegal = 0, rsp_seq = 0, two cycles after cmd_valid.
- Arithmetic wrap and logic ops, back-to-back at 1/cycle:
  - 0x0000 − 0x0001 → 0xFFFF
  - 0xFFFF + 0x0001 → 0x0000
  - 0xF0F0 & 0x3C3C → 0x3030
  - 0xF0F0 | 0x0F0F → 0xFFFF
  - 0xAAAA ^ 0xFFFF → 0x5555
  - expected rsp_seq 0,1,2,3,4
- Backpressure with rsp_ready = 0 and 8 commands offered:
  - exactly 5 accepted; cmd_ready falls after the 5th; count = 4
  - rsp_data is stable at result 0
  - after releasing rsp_ready, results 0–4 drain in order
- Illegal opcode: sel = 110, a = 0x1111, b = 0x2222 → rsp_data = 0x0000, rsp_illegal = 1. The following legal command is unaffected.
- Sequence wrap: 257 commands → rsp_seq 255 is followed by 0, then 1.
- Reset mid-stream with 3 commands queued and a response held:
  - after reset, rsp_valid = 0, count = 0, alu_* = 0, cmd_ready = 1
  - the next response has rsp_seq = 0

Source files
------------

// File: rtl/alu_cmd_issue_if.sv
// Command and response handshake bundle for the ALU issue stage.
// The producer/consumer side takes the master modport; the issue stage takes the slave modport.
interface alu_cmd_issue_if #(
  parameter int WIDTH = 16,
  parameter int SEQW  = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_sel;
  logic             rsp_illegal;
  logic [SEQW-1:0]  rsp_seq;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_sel, rsp_illegal, rsp_seq
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_sel, rsp_illegal, rsp_seq
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command FIFO in front of the combinational ALU and a registered response slot behind it.
// The FIFO head drives the ALU; its result is captured into the slot whenever the slot can take it.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int SEQW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_cmd_issue_if.slave          io,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [2:0]              alu_sel,
  input  logic [WIDTH-1:0]        alu_out,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQW-1:0]  seq_q, seq_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]       rsp_sel_q, rsp_sel_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [SEQW-1:0]  rsp_seq_q, rsp_seq_d;

  logic   full, empty, push, pop;
  entry_t head;

  // Ready ignores a same-cycle pop so rsp_ready never reaches cmd_ready combinationally.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign io.cmd_ready = !full && !rst;
  assign push         = io.cmd_valid && io.cmd_ready;
  assign pop          = !empty && (!rsp_valid_q || io.rsp_ready);
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.sel;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{a: io.cmd_a, b: io.cmd_b, sel: io.cmd_sel};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Illegal opcodes flow through like any other; the ALU already returns zero for them.
  always_comb begin
    seq_d         = seq_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_sel_d     = rsp_sel_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_seq_d     = rsp_seq_q;
    if (pop) begin
      rsp_valid_d   = 1'b1;
      rsp_data_d    = alu_out;
      rsp_sel_d     = head.sel;
      rsp_illegal_d = (head.sel >= 3'b101);
      rsp_seq_d     = seq_q;
      seq_d         = seq_q + SEQW'(1);
    end else if (rsp_valid_q && io.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      seq_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_sel_q     <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_seq_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      seq_q         <= seq_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_sel_q     <= rsp_sel_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_seq_q     <= rsp_seq_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign io.rsp_valid   = rsp_valid_q;
  assign io.rsp_data    = rsp_data_q;
  assign io.rsp_sel     = rsp_sel_q;
  assign io.rsp_illegal = rsp_illegal_q;
  assign io.rsp_seq     = rsp_seq_q;
  assign count          = count_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: directed commands push expected responses into a scoreboard
// queue, and an independent monitor pops and compares every response the DUT hands over.
module tb_alu_cmd_issue;

  localparam int WIDTH = 16;
  localparam int SEQW  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_issue_if #(.WIDTH(WIDTH), .SEQW(SEQW)) bus ();

  logic [WIDTH-1:0]       alu_a, alu_b, alu_out;
  logic [2:0]             alu_sel;
  logic [$clog2(DEPTH):0] count;

  alu_cmd_issue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEQW(SEQW)) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .count   (count)
  );

  // Stand-in for the combinational ALU sitting between alu_* and alu_out.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [15:0] data;
    logic [2:0]  sel;
    logic        ill;
    logic [7:0]  seq;
  } rsp_t;

  rsp_t       sb_q[$];
  rsp_t       mon_e;
  rsp_t       new_e;
  int         checks = 0;
  int         errors = 0;
  int         stall_cycles = 0;
  logic [7:0] exp_seq = 8'h00;
  logic [7:0] last_seq = 8'h00;
  bit         have_last = 1'b0;
  bit         saw_wrap = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // Holds the command until accepted, then records what the response must look like.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel,
                               input logic [15:0] exp_data, input logic exp_ill);
    int  wait_cyc = 0;
    bit  done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    while (!done) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        new_e.data = exp_data;
        new_e.sel  = sel;
        new_e.ill  = exp_ill;
        new_e.seq  = exp_seq;
        sb_q.push_back(new_e);
        exp_seq++;
        done = 1'b1;
      end else begin
        wait_cyc++;
        stall_cycles++;
        if (wait_cyc > 50) begin
          failNow("cmd_accept_timeout");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitEmpty();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) failNow("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        failNow("unexpected_rsp");
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
        checkOutput("rsp_sel", 32'(bus.rsp_sel), 32'(mon_e.sel));
        checkOutput("rsp_illegal", 32'(bus.rsp_illegal), 32'(mon_e.ill));
        checkOutput("rsp_seq", 32'(bus.rsp_seq), 32'(mon_e.seq));
        if (have_last && last_seq == 8'hFF && bus.rsp_seq == 8'h00) saw_wrap = 1'b1;
        last_seq  = bus.rsp_seq;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    int idx;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_sel", 32'(alu_sel), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("post_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("post_rst_rsp_seq", 32'(bus.rsp_seq), 32'd0);
    checkOutput("post_rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] single add and latency");
    bus.rsp_ready = 1'b1;
    applyStimulus(16'h1234, 16'h0001, 3'b000, 16'h1235, 1'b0);
    @(negedge clk);
    checkOutput("lat_valid_early", 32'(bus.rsp_valid), 32'd0);
    checkOutput("head_alu_a", 32'(alu_a), 32'h1234);
    checkOutput("head_alu_b", 32'(alu_b), 32'h0001);
    checkOutput("head_count", 32'(count), 32'd1);
    @(negedge clk);
    checkOutput("lat_valid_on_time", 32'(bus.rsp_valid), 32'd1);
    waitEmpty();

    $display("[TB] back-to-back wrap and logic ops");
    stall_cycles = 0;
    applyStimulus(16'h0000, 16'h0001, 3'b001, 16'hFFFF, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b0);
    applyStimulus(16'hF0F0, 16'h3C3C, 3'b010, 16'h3030, 1'b0);
    applyStimulus(16'hF0F0, 16'h0F0F, 3'b011, 16'hFFFF, 1'b0);
    applyStimulus(16'hAAAA, 16'hFFFF, 3'b100, 16'h5555, 1'b0);
    checkOutput("burst_stalls", 32'(stall_cycles), 32'd0);
    waitEmpty();

    $display("[TB] backpressure");
    bus.rsp_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 16'h1000 + 16'(idx);
      bus.cmd_b     = 16'h0001;
      bus.cmd_sel   = 3'b000;
      @(negedge clk);
      if (bus.cmd_ready) begin
        new_e.data = 16'h1001 + 16'(idx);
        new_e.sel  = 3'b000;
        new_e.ill  = 1'b0;
        new_e.seq  = exp_seq;
        sb_q.push_back(new_e);
        exp_seq++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    checkOutput("bp_accepted", 32'(idx), 32'd5);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checkOutput("bp_count", 32'(count), 32'd4);
      checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_hold_data", 32'(bus.rsp_data), 32'h1001);
      checkOutput("bp_hold_seq", 32'(bus.rsp_seq), 32'd6);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    waitEmpty();

    $display("[TB] illegal opcode");
    applyStimulus(16'h1111, 16'h2222, 3'b110, 16'h0000, 1'b1);
    applyStimulus(16'h1111, 16'h2222, 3'b100, 16'h3333, 1'b0);
    waitEmpty();

    $display("[TB] sequence wrap");
    for (int i = 0; i < 257; i++) begin
      applyStimulus(16'(i), 16'h0100, 3'b000, 16'(i) + 16'h0100, 1'b0);
    end
    waitEmpty();
    checkOutput("seq_wrap_seen", 32'(saw_wrap), 32'd1);

    $display("[TB] reset mid-stream");
    bus.rsp_ready = 1'b0;
    applyStimulus(16'd10, 16'd3, 3'b001, 16'd7, 1'b0);
    applyStimulus(16'd20, 16'd3, 3'b001, 16'd17, 1'b0);
    applyStimulus(16'd30, 16'd3, 3'b001, 16'd27, 1'b0);
    applyStimulus(16'd40, 16'd3, 3'b001, 16'd37, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    checkOutput("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    exp_seq = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("mid_rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    applyStimulus(16'h00FF, 16'h0F00, 3'b011, 16'h0FFF, 1'b0);
    waitEmpty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
